// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage sitting directly behind the program counter. An accepted PC
// becomes a single-word read on the instruction memory req/ack interface.
// The returned word is buffered together with its PC in a small
// first-word-fall-through FIFO that feeds the decoder over valid/ready.
// At most one memory request is outstanding at any time.
//
// Optional feature (compile-time macro FETCH_PARITY_EN):
//   defined   - the top bit of each word is an even-parity bit over the
//               lower bits; a per-entry error flag is stored on push and
//               reported on instr_perr for the head entry.
//   undefined - no parity storage, instr_perr is tied to 0.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   reset        synchronous, active-low reset
//   pc_in        address to fetch
//   pc_valid     pc_in is valid this cycle
//   pc_ready     pc_in accepted this cycle (PC may advance)
//   mem_req      memory read request, held until mem_ack
//   mem_addr     memory read address, stable while mem_req is high
//   mem_ack      read data valid, completes the request
//   mem_rdata    read data
//   flush        discard buffered and in-flight fetches
//   instr_out    head-of-FIFO instruction word (0 while empty)
//   instr_pc     PC of instr_out (0 while empty)
//   instr_valid  FIFO is non-empty
//   instr_ready  decoder consumes the head entry when valid
//   fifo_count   number of occupied entries, 0..DEPTH
//   instr_perr   parity error flag of the head entry
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              flush,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              instr_perr
);

  localparam int PTR_W = CNT_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    DROP
  } state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_empty;
  logic              has_room;
  logic              push;
  logic              pop;

  assign fifo_empty = (count == '0);
  assign has_room   = (count < CNT_W'(DEPTH));

  // Only IDLE can issue, so the slot for the outstanding word is already
  // reserved by the room check and the later push can never overflow.
  // Gating with reset keeps the PC from advancing while reset is held.
  assign pc_ready = reset && (state == IDLE) && pc_valid && !flush && has_room;

  // A flush kills both a returning word and a simultaneous pop.
  assign push = (state == WAIT_ACK) && mem_ack && !flush;
  assign pop  = instr_ready && !fifo_empty && !flush;

  // The request stays up in both WAIT_ACK and DROP because an issued
  // read cannot be withdrawn; it only falls once the ack returns.
  assign mem_req = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pc_ready) begin
          next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          next_state = IDLE;
        end else if (flush) begin
          next_state = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_addr <= '0;
    end else if (pc_ready) begin
      mem_addr <= pc_in;
    end
  end

  // Entry storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= mem_addr;
      data_q[wr_ptr] <= mem_rdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign instr_valid = !fifo_empty;
  assign fifo_count  = count;
  assign instr_out   = fifo_empty ? '0 : data_q[rd_ptr];
  assign instr_pc    = fifo_empty ? '0 : addr_q[rd_ptr];

`ifdef FETCH_PARITY_EN
  logic perr_q [DEPTH];

  // Even parity over the whole word: any odd number of ones is an error.
  always_ff @(posedge clk) begin
    if (push) begin
      perr_q[wr_ptr] <= ^mem_rdata;
    end
  end

  assign instr_perr = !fifo_empty && perr_q[rd_ptr];
`else
  assign instr_perr = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter.
- Takes the 8-bit PC, issues single-word reads to instruction memory over a req/ack handshake, and buffers returned words with their PC in a small FIFO.
- Presents words to the decoder with valid/ready.
- Back-pressures the PC via pc_ready; supports flush on branch.

Parameters:
ADDR_W, 8, PC/memory address width
DATA_W, 32, instruction word width
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 3, width of fifo_count; must equal log2(DEPTH)+1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
pc_in  in  ADDR_W  address to fetch
pc_valid  in  1  pc_in is valid this cycle
pc_ready  out  1  fetch accepted pc_in this cycle (PC may advance)
mem_req  out  1  memory read request
mem_addr  out  ADDR_W  memory read address
mem_ack  in  1  read data valid, completes request
mem_rdata  in  DATA_W  read data
flush  in  1  discard buffered and in-flight fetches
instr_out  out  DATA_W  head-of-FIFO instruction
instr_pc  out  ADDR_W  PC of instr_out
instr_valid  out  1  FIFO non-empty
instr_ready  in  1  decoder consumes head when valid
fifo_count  out  CNT_W  occupied entries, 0..DEPTH
instr_perr  out  1  parity error flag of head entry (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge) forces the following, overriding all inputs:
  - state=IDLE
  - mem_req=0, mem_addr=0
  - FIFO empty, fifo_count=0, instr_valid=0
  - instr_out/instr_pc/instr_perr read 0 while empty
- pc_ready is combinational: pc_ready = (state==IDLE) && pc_valid && !flush && (fifo_count < DEPTH).
- States:
  - IDLE:
    - if pc_ready, latch mem_addr<=pc_in, assert mem_req next cycle, go to WAIT_ACK.
    - else stay.
  - WAIT_ACK:
    - mem_req held 1 and mem_addr stable until mem_ack.
    - On mem_ack with no flush: push {mem_addr, mem_rdata}, mem_req<=0, go to IDLE.
    - On flush without mem_ack: mem_req stays 1 (request cannot be withdrawn), go to DROP.
    - On flush with mem_ack in the same cycle: data discarded, go to IDLE.
  - DROP:
    - mem_req held until mem_ack.
    - On mem_ack, data discarded, mem_req<=0, go to IDLE.
    - Further flush has no extra effect.
- Issue rate and latency:
  - At most one outstanding request.
  - With mem_ack one cycle after mem_req rises, best throughput is one fetch per 3 cycles (IDLE, WAIT_ACK, ack).
  - Latency from pc_ready to instr_valid is at least 3 cycles.
- Room reservation:
  - Issue is allowed only when fifo_count < DEPTH at the pc_ready cycle.
  - A slot is reserved for the outstanding word, so the push in WAIT_ACK never overflows.
  - The check uses fifo_count + (state!=IDLE) < DEPTH; since state==IDLE is required, fifo_count < DEPTH suffices.
- FIFO:
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
  - instr_out/instr_pc are registered from the head entry, FWFT: valid the cycle after the push edge.
- flush:
  - Empties the FIFO at that edge (count<=0, instr_valid<=0). A simultaneous pop or push is dropped.
  - pc_ready=0 during flush, so the new target PC is taken from the following cycle.
- mem_ack while IDLE: ignored.
- Reset mid-request: mem_req drops at the reset edge; the memory side must tolerate abandonment.

Optional Feature:
FETCH_PARITY_EN
- Defined:
  - The top bit of each stored word is treated as an even-parity bit over mem_rdata[DATA_W-2:0].
  - On push, perr = ^mem_rdata (nonzero means error) is stored per entry.
  - instr_perr reports the head entry's flag, qualified by instr_valid.
  - No flow change: errored words are still delivered.
- Undefined: no parity storage; instr_perr tied 0.

Test Plan:
- Reset with pc_valid=1, pc_in=0x05 -> pc_ready=0, mem_req=0, fifo_count=0, instr_valid=0; first edge after reset release accepts 0x05, mem_addr=0x05.
- pc 0x00..0x03 with mem_ack one cycle after req, mem_rdata=0xA0000000+addr, instr_ready=0 -> fifo_count reaches 4, pc_ready=0 with pc_valid=1; then instr_ready=1 pops 0xA0000000..0xA0000003 with instr_pc 0x00..0x03 in order.
- Full FIFO (count=4) with simultaneous pop and pending pc_valid -> pop first, pc_ready=1 next cycle; push and pop same cycle keeps count constant.
- flush in WAIT_ACK, mem_ack 2 cycles later with 0xDEADBEEF -> state DROP, word never appears, fifo_count=0; next pc 0x40 fetched normally.
- flush in the same cycle as mem_ack -> data discarded, IDLE next cycle, count=0.
- FETCH_PARITY_EN defined, mem_rdata=0x00000001 -> instr_perr=1; 0x80000001 -> instr_perr=0. Undefined -> instr_perr=0 for both.
